// File: rtl/p4_share_arbiter.sv
// Round-robin arbiter sharing one external P4 adder among NREQ requesters, one op in flight.
// Optional: define P4_ARB_OVF_EN to add rsp_ovf, the signed overflow captured with the sum.
module p4_share_arbiter #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned NREQ      = 4,
    parameter int unsigned ADDER_LAT = 1,
    parameter int unsigned CNTW      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*DWIDTH-1:0]   req_a,
    input  logic [NREQ*DWIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic [DWIDTH-1:0]        add_a,
    output logic [DWIDTH-1:0]        add_b,
    output logic                     add_cin,
    input  logic [DWIDTH-1:0]        add_s,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DWIDTH-1:0]        rsp_sum,
    output logic                     rsp_cout,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy,
    output logic [CNTW-1:0]          op_count
`ifdef P4_ARB_OVF_EN
    ,
    output logic                     rsp_ovf
`endif
);
    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned LATW = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [LATW-1:0]   cnt_q, cnt_d;
    logic [DWIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              cin_q, cin_d, cout_q, cout_d, vld_q, vld_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [CNTW-1:0]   opc_q, opc_d;

    logic [DWIDTH-1:0] a_arr [NREQ];
    logic [DWIDTH-1:0] b_arr [NREQ];
    logic              grant_vld;
    logic [IDW-1:0]    grant_idx, scan_idx;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DWIDTH +: DWIDTH];
        assign b_arr[i] = req_b[i*DWIDTH +: DWIDTH];
    end

    // Scan from the highest rotation offset down so the one nearest the pointer wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(ptr_q) + k) % int'(NREQ));
            if (req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

`ifdef P4_ARB_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        id_d      = id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        vld_d     = vld_q;
        opc_d     = opc_q;
        req_ready = '0;
`ifdef P4_ARB_OVF_EN
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    req_ready = rst_n ? (NREQ'(1) << grant_idx) : '0;
                    a_d       = a_arr[grant_idx];
                    b_d       = b_arr[grant_idx];
                    cin_d     = req_cin[grant_idx];
                    id_d      = grant_idx;
                    ptr_d     = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d     = LATW'(ADDER_LAT - 1);
                    state_d   = StExec;
                end
            end
            StExec: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    sum_d   = add_s;
                    cout_d  = add_cout;
                    vld_d   = 1'b1;
                    state_d = StResp;
`ifdef P4_ARB_OVF_EN
                    ovf_d   = (a_q[DWIDTH-1] == b_q[DWIDTH-1]) &&
                              (add_s[DWIDTH-1] != a_q[DWIDTH-1]);
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    vld_d   = 1'b0;
                    opc_d   = opc_q + 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            id_q    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            vld_q   <= 1'b0;
            opc_q   <= '0;
`ifdef P4_ARB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            vld_q   <= vld_d;
            opc_q   <= opc_d;
`ifdef P4_ARB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign rsp_valid = vld_q;
    assign rsp_sum   = sum_q;
    assign rsp_cout  = cout_q;
    assign rsp_id    = id_q;
    assign op_count  = opc_q;
    assign busy      = (state_q != StIdle);
`ifdef P4_ARB_OVF_EN
    assign rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_p4_share_arbiter.sv
// Bench for p4_share_arbiter: random and directed traffic against a round-robin reference model.
module tb_p4_share_arbiter;
    localparam int unsigned DWIDTH    = 32;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned ADDER_LAT = 1;
    localparam int unsigned CNTW      = 16;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*DWIDTH-1:0]   req_a;
    logic [NREQ*DWIDTH-1:0]   req_b;
    logic [NREQ-1:0]          req_cin;
    logic [DWIDTH-1:0]        add_a;
    logic [DWIDTH-1:0]        add_b;
    logic                     add_cin;
    logic [DWIDTH-1:0]        add_s;
    logic                     add_cout;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DWIDTH-1:0]        rsp_sum;
    logic                     rsp_cout;
    logic [1:0]               rsp_id;
    logic                     busy;
    logic [CNTW-1:0]          op_count;
`ifdef P4_ARB_OVF_EN
    logic                     rsp_ovf;
`endif

    p4_share_arbiter #(
        .DWIDTH    (DWIDTH),
        .NREQ      (NREQ),
        .ADDER_LAT (ADDER_LAT),
        .CNTW      (CNTW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
`ifdef P4_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Stand-in for the combinational P4 adder.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{DWIDTH{1'b0}}, add_cin};

    typedef struct packed {
        logic [DWIDTH-1:0] sum;
        logic              cout;
        logic [1:0]        id;
        logic              ovf;
    } rsp_t;

    rsp_t              exp_q[$];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                acc_cyc = 0;
    int                ptr_m = 0;
    bit                outstanding = 1'b0;
    logic [CNTW-1:0]   exp_cnt = '0;
    logic [DWIDTH-1:0] exp_a, exp_b;
    logic              exp_cin;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DWIDTH-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic set_req(input int i, input logic [DWIDTH-1:0] a, input logic [DWIDTH-1:0] b,
                           input logic cin);
        req_a[i*DWIDTH +: DWIDTH] = a;
        req_b[i*DWIDTH +: DWIDTH] = b;
        req_cin[i]                = cin;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NREQ; i++) set_req(i, rand_op(), rand_op(), 1'($urandom_range(0, 1)));
    endtask

    // Reference model: one op at a time, round-robin from ptr_m, result = a + b + cin.
    task automatic step();
        int                g;
        rsp_t              e;
        logic [DWIDTH:0]   full;
        logic [DWIDTH-1:0] a, b;
        logic              cin;
        #1;
        if (!outstanding) begin
            chk("busy_idle", busy, 0);
            chk("rsp_valid_idle", rsp_valid, 0);
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_valid[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
            if (g < 0) begin
                chk("req_ready_none", req_ready, 0);
            end else begin
                chk("req_ready_grant", req_ready, 64'(1) << g);
                a      = req_a[g*DWIDTH +: DWIDTH];
                b      = req_b[g*DWIDTH +: DWIDTH];
                cin    = req_cin[g];
                full   = {1'b0, a} + {1'b0, b} + {{DWIDTH{1'b0}}, cin};
                e.sum  = full[DWIDTH-1:0];
                e.cout = full[DWIDTH];
                e.id   = 2'(g);
                e.ovf  = (a[DWIDTH-1] == b[DWIDTH-1]) && (e.sum[DWIDTH-1] != a[DWIDTH-1]);
                exp_q.push_back(e);
                exp_a       = a;
                exp_b       = b;
                exp_cin     = cin;
                outstanding = 1'b1;
                acc_cyc     = cyc;
                ptr_m       = (g + 1) % NREQ;
            end
        end else begin
            chk("req_ready_busy", req_ready, 0);
            chk("busy", busy, 1);
            chk("add_a", add_a, exp_a);
            chk("add_b", add_b, exp_b);
            chk("add_cin", add_cin, exp_cin);
            chk("rsp_valid_timing", rsp_valid, (cyc > acc_cyc + int'(ADDER_LAT)) ? 1 : 0);
        end
        @(negedge clk);
        cyc++;
    endtask

    // Monitor: compares whatever response the DUT presents against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            chk("op_count", op_count, exp_cnt);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got rsp_valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    chk("rsp_sum", rsp_sum, exp_q[0].sum);
                    chk("rsp_cout", rsp_cout, exp_q[0].cout);
                    chk("rsp_id", rsp_id, exp_q[0].id);
`ifdef P4_ARB_OVF_EN
                    chk("rsp_ovf", rsp_ovf, exp_q[0].ovf);
`endif
                    if (rsp_ready) begin
                        void'(exp_q.pop_front());
                        exp_cnt     = exp_cnt + 1'b1;
                        outstanding = 1'b0;
                    end
                end
            end
        end
    end

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
    endtask

    initial begin
        int guard;
        req_valid = '1;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rand_ops();
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);
        chk("rst_add_cin", add_cin, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_sum", rsp_sum, 0);
        chk("rst_rsp_cout", rsp_cout, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_op_count", op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters continuously valid: rotation 0,1,2,3,0.
        req_valid = '1;
        repeat (14) begin
            rand_ops();
            step();
        end
        drain();

        req_valid = '0;
        set_req(0, 32'd5, 32'd7, 1'b1);
        req_valid = 4'b0001;
        step();
        drain();

        set_req(2, 32'hFFFF_FFFF, 32'd1, 1'b0);
        req_valid = 4'b0100;
        step();
        drain();

        // Response back-pressure while other requesters wait.
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        step();
        req_valid = '1;
        repeat (7) step();
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (5) step();

        // Reset asserted while an op is executing.
        req_valid = '1;
        rsp_ready = 1'b1;
        guard     = 0;
        while (!(outstanding && cyc == acc_cyc + 1) && guard < 20) begin
            step();
            guard++;
        end
        chk("reach_exec", (guard < 20) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_add_a", add_a, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_op_count", op_count, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        exp_q.delete();
        outstanding = 1'b0;
        ptr_m       = 0;
        exp_cnt     = '0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        repeat (4) step();
        drain();

`ifdef P4_ARB_OVF_EN
        set_req(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        req_valid = 4'b0001;
        step();
        drain();
        set_req(1, 32'd1, 32'd1, 1'b0);
        req_valid = 4'b0010;
        step();
        drain();
`endif

        for (int n = 0; n < 400; n++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
